// File: rtl/dsq2_pkg.sv
// Shared widths and decode constants for the dsq2 sum-of-squared-differences coprocessor.
// DSQ2_DECODE_EN (optional) restricts acceptance to the custom-0 dsq2 encoding.
package dsq2_pkg;
  localparam int LANE_W    = 8;
  localparam int NUM_LANES = 4;
  localparam int SQ_W      = 17;
  localparam int SUM_W     = 19;

  localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;
  localparam logic [6:0] F7_DSQ2     = 7'b0000001;

  function automatic logic is_dsq2(input logic [31:0] instr);
    return (instr[6:0] == OPC_CUSTOM0) && (instr[31:25] == F7_DSQ2);
  endfunction
endpackage

// File: rtl/dsq2_lane.sv
// One byte lane: squared difference of two unsigned bytes, purely combinational.
// The square of the signed difference equals the square of its magnitude.
module dsq2_lane
  import dsq2_pkg::*;
(
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  output logic [SQ_W-1:0]   sq
);
  logic [LANE_W-1:0]   mag;
  logic [2*LANE_W-1:0] prod;

  always_comb begin
    mag  = (a >= b) ? (a - b) : (b - a);
    prod = {{LANE_W{1'b0}}, mag} * {{LANE_W{1'b0}}, mag};
    sq   = {1'b0, prod};
  end
endmodule

// File: rtl/dsq2.sv
// PCPI coprocessor: rd = sum over four byte lanes of (rs1 byte - rs2 byte)^2, one-cycle latency.
// Define DSQ2_DECODE_EN to accept only the custom-0 / funct7=0000001 instruction.
module dsq2
  import dsq2_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [31:0] instr,
  input  logic        valid,
  output logic        ready,
  output logic        wait_,
  output logic [31:0] rd,
  output logic        wr
);
  logic [SQ_W-1:0]  lane_sq [NUM_LANES];
  logic [SQ_W:0]    sum_lo;
  logic [SQ_W:0]    sum_hi;
  logic [SUM_W-1:0] sum;
  logic             accept;
  logic             ready_d, ready_q;
  logic [31:0]      rd_d, rd_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      dsq2_lane u_lane (
        .a  (rs1[gi*LANE_W +: LANE_W]),
        .b  (rs2[gi*LANE_W +: LANE_W]),
        .sq (lane_sq[gi])
      );
    end
  endgenerate

`ifdef DSQ2_DECODE_EN
  assign accept = valid && is_dsq2(instr);
`else
  logic unused_instr;
  assign unused_instr = ^instr;
  assign accept       = valid;
`endif

  always_comb begin
    sum_lo  = {1'b0, lane_sq[0]} + {1'b0, lane_sq[1]};
    sum_hi  = {1'b0, lane_sq[2]} + {1'b0, lane_sq[3]};
    sum     = {1'b0, sum_lo} + {1'b0, sum_hi};
    ready_d = accept;
    // rd keeps the previous result when nothing is accepted.
    rd_d    = accept ? {{(32-SUM_W){1'b0}}, sum} : rd_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ready_q <= 1'b0;
      rd_q    <= 32'd0;
    end else begin
      ready_q <= ready_d;
      rd_q    <= rd_d;
    end
  end

  assign ready = ready_q;
  assign wr    = ready_q;
  assign rd    = rd_q;
  assign wait_ = 1'b0;
endmodule

// File: tb/tb_dsq2.sv
// Directed self-checking bench for dsq2: reset, arithmetic vectors, handshake, back-to-back, reset while pending.
module tb_dsq2;
  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] rs1, rs2, instr;
  logic        valid;
  logic        ready, wait_, wr;
  logic [31:0] rd;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] INSTR_OK = {7'b0000001, 18'd0, 7'b0001011};

  dsq2 dut (
    .clk    (clk),
    .resetn (resetn),
    .rs1    (rs1),
    .rs2    (rs2),
    .instr  (instr),
    .valid  (valid),
    .ready  (ready),
    .wait_  (wait_),
    .rd     (rd),
    .wr     (wr)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    valid = v;
    rs1   = a;
    rs2   = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    valid  = 1'b0;
    rs1    = 32'hFFFF_FFFF;
    rs2    = 32'd0;
    instr  = INSTR_OK;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%0b want=0", ready); end
    checks++; if (wr !== 1'b0)    begin errors++; $display("FAIL reset_wr got=%0b want=0", wr); end
    checks++; if (rd !== 32'd0)   begin errors++; $display("FAIL reset_rd got=%0d want=0", rd); end
    checks++; if (wait_ !== 1'b0) begin errors++; $display("FAIL reset_wait got=%0b want=0", wait_); end
    @(negedge clk);
    resetn = 1'b1;
    $display("reset: ready=%0b wr=%0b rd=%0d", ready, wr, rd);
  endtask

  task automatic test_equal();
    drive(1'b1, 32'h0A0A_0A0A, 32'h0A0A_0A0A);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL equal_ready got=%0b want=1", ready); end
    checks++; if (wr !== 1'b1)    begin errors++; $display("FAIL equal_wr got=%0b want=1", wr); end
    checks++; if (wait_ !== 1'b0) begin errors++; $display("FAIL equal_wait got=%0b want=0", wait_); end
    checks++; if (rd !== 32'd0)   begin errors++; $display("FAIL equal_rd got=%0d want=0", rd); end
    $display("equal: rs1=0a0a0a0a rs2=0a0a0a0a rd=%0d ready=%0b", rd, ready);
    drive(1'b0, 32'h0, 32'h0);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL equal_drop_ready got=%0b want=0", ready); end
    checks++; if (wr !== 1'b0)    begin errors++; $display("FAIL equal_drop_wr got=%0b want=0", wr); end
  endtask

  task automatic test_vectors();
    logic [31:0] va [4] = '{32'h141E_0F00, 32'hFFFF_FFFF, 32'h8040_0100, 32'h0304_0A06};
    logic [31:0] vb [4] = '{32'h0A0A_0F0A, 32'h0000_0000, 32'h0020_FF7F, 32'h0507_0B09};
    logic [31:0] ve [4] = '{32'd600, 32'd260100, 32'd98053, 32'd23};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, va[i], vb[i]);
      checks++; if (rd !== ve[i])   begin errors++; $display("FAIL vec%0d_rd got=%0d want=%0d", i, rd, ve[i]); end
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL vec%0d_ready got=%0b want=1", i, ready); end
      $display("vector %0d: rs1=%h rs2=%h rd=%0d", i, va[i], vb[i], rd);
      // Operands change with valid low: result must hold, handshake must drop.
      drive(1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL vec%0d_drop_ready got=%0b want=0", i, ready); end
      checks++; if (wr !== 1'b0)    begin errors++; $display("FAIL vec%0d_drop_wr got=%0b want=0", i, wr); end
      checks++; if (rd !== ve[i])   begin errors++; $display("FAIL vec%0d_hold_rd got=%0d want=%0d", i, rd, ve[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] va [3] = '{32'h141E_0F00, 32'h0304_0A06, 32'hFFFF_FFFF};
    logic [31:0] vb [3] = '{32'h0A0A_0F0A, 32'h0507_0B09, 32'h0000_0000};
    logic [31:0] ve [3] = '{32'd600, 32'd23, 32'd260100};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, va[i], vb[i]);
      checks++; if (ready !== 1'b1 || wr !== 1'b1) begin errors++; $display("FAIL b2b%0d_hs got=%0b%0b want=11", i, ready, wr); end
      checks++; if (rd !== ve[i]) begin errors++; $display("FAIL b2b%0d_rd got=%0d want=%0d", i, rd, ve[i]); end
      $display("back_to_back %0d: rd=%0d ready=%0b", i, rd, ready);
    end
    drive(1'b0, 32'h0, 32'h0);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL b2b_end_ready got=%0b want=0", ready); end
  endtask

  task automatic test_reset_pending();
    drive(1'b1, 32'h8040_0100, 32'h0020_FF7F);
    checks++; if (rd !== 32'd98053) begin errors++; $display("FAIL rstp_pre_rd got=%0d want=98053", rd); end
    // Another request arrives together with reset; reset must win.
    @(negedge clk);
    valid  = 1'b1;
    rs1    = 32'hFFFF_FFFF;
    rs2    = 32'h0;
    resetn = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rstp_ready got=%0b want=0", ready); end
    checks++; if (wr !== 1'b0)    begin errors++; $display("FAIL rstp_wr got=%0b want=0", wr); end
    checks++; if (rd !== 32'd0)   begin errors++; $display("FAIL rstp_rd got=%0d want=0", rd); end
    $display("reset_pending: ready=%0b rd=%0d", ready, rd);
    @(negedge clk);
    resetn = 1'b1;
    valid  = 1'b0;
  endtask

`ifdef DSQ2_DECODE_EN
  task automatic test_decode();
    drive(1'b1, 32'h141E_0F00, 32'h0A0A_0F0A);
    @(negedge clk);
    instr = 32'h0000_0033;
    valid = 1'b1;
    rs1   = 32'hFFFF_FFFF;
    rs2   = 32'h0;
    @(posedge clk);
    #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL decode_ready got=%0b want=0", ready); end
    checks++; if (rd !== 32'd600) begin errors++; $display("FAIL decode_rd got=%0d want=600", rd); end
    $display("decode: nonmatching instr ready=%0b rd=%0d", ready, rd);
    @(negedge clk);
    instr = INSTR_OK;
    valid = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_equal();
    test_vectors();
    test_back_to_back();
    test_reset_pending();
`ifdef DSQ2_DECODE_EN
    test_decode();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
